parity_frame_generator: RTL and testbench

- Transmit-side counterpart of the team's serial parity checker.
- Accepts a parallel data word over a valid/ready handshake and shifts it out serially, LSB first, one bit per clock.
- Appends one parity bit after the data bits, so each frame is DATA_W+1 bits.
- Feeds a serial link or the serial parity checker.

---
 rtl/parity_frame_generator.sv | 123 ++++++++++++
 tb/tb_parity_frame_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_generator.sv
// Serial parity frame generator: shifts a parallel word out LSB first, then one parity bit.
// Optional macro PARGEN_BACK_TO_BACK_EN allows contiguous frames by accepting a word during the parity cycle.
module parity_frame_generator #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              frame_end,
    output logic              busy
);

    localparam int unsigned    CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nx;
    logic              parity;
    logic              parity_nx;
    logic              serial_nx;
    logic              bit_valid_nx;
    logic              frame_end_nx;
    logic              accept;

    always_comb begin
        data_ready = (state == IDLE);
`ifdef PARGEN_BACK_TO_BACK_EN
        if (state == PAR) begin
            data_ready = 1'b1;
        end
`endif
    end

    assign accept = data_valid & data_ready;
    assign busy   = (state == DATA) || (state == PAR);

    // serial_out is registered, so each branch computes the bit that will be on the line next cycle.
    always_comb begin
        state_nx     = state;
        shift_nx     = shift_reg;
        count_nx     = count;
        parity_nx    = parity;
        serial_nx    = 1'b0;
        bit_valid_nx = 1'b0;
        frame_end_nx = 1'b0;

        case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            DATA: begin
                shift_nx     = shift_reg >> 1;
                count_nx     = count + 1'b1;
                parity_nx    = parity ^ shift_reg[0];
                bit_valid_nx = 1'b1;
                serial_nx    = shift_nx[0];
                if (count == LAST_BIT) begin
                    state_nx     = PAR;
                    count_nx     = '0;
                    serial_nx    = parity ^ shift_reg[0] ^ PARITY_ODD;
                    frame_end_nx = 1'b1;
                end
            end
            PAR: begin
                state_nx  = IDLE;
                parity_nx = 1'b0;
            end
            default: begin
                state_nx  = IDLE;
                shift_nx  = '0;
                count_nx  = '0;
                parity_nx = 1'b0;
            end
        endcase

        // Accept is only possible in IDLE, or in PAR when back-to-back frames are enabled.
        if (accept) begin
            state_nx     = DATA;
            shift_nx     = data_in;
            count_nx     = '0;
            parity_nx    = 1'b0;
            serial_nx    = data_in[0];
            bit_valid_nx = 1'b1;
            frame_end_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            count      <= '0;
            parity     <= 1'b0;
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            count      <= count_nx;
            parity     <= parity_nx;
            serial_out <= serial_nx;
            bit_valid  <= bit_valid_nx;
            frame_end  <= frame_end_nx;
        end
    end

endmodule

// File: tb/tb_parity_frame_generator.sv
// Scoreboard bench: even- and odd-parity instances driven in lockstep, monitors compare serial bits.
module tb_parity_frame_generator;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;

    logic rdy0, so0, bv0, fe0, busy0;
    logic rdy1, so1, bv1, fe1, busy1;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parity_frame_generator #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy0), .serial_out(so0), .bit_valid(bv0), .frame_end(fe0), .busy(busy0)
    );

    parity_frame_generator #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy1), .serial_out(so1), .bit_valid(bv1), .frame_end(fe1), .busy(busy1)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor for the even-parity instance: checks bits, frame_end and frame parity.
    logic par0 = 1'b0;
    logic pfe0 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            par0 = 1'b0;
            pfe0 = 1'b0;
        end else begin
`ifndef PARGEN_BACK_TO_BACK_EN
            if (pfe0) chk("gap_after_frame_even", bv0, 1'b0);
`endif
            if (bv0) begin
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit_even: got bit_valid 1 expected no bit at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    chk("serial_even", so0, e.b);
                    chk("frame_end_even", fe0, e.last);
                    par0 = par0 ^ so0;
                    if (fe0) begin
                        chk("checker_state_even", par0, 1'b0);
                        par0 = 1'b0;
                    end
                end
            end else begin
                chk("frame_end_idle_even", fe0, 1'b0);
            end
            pfe0 = fe0;
        end
    end

    logic par1 = 1'b0;
    logic pfe1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            par1 = 1'b0;
            pfe1 = 1'b0;
        end else begin
`ifndef PARGEN_BACK_TO_BACK_EN
            if (pfe1) chk("gap_after_frame_odd", bv1, 1'b0);
`endif
            if (bv1) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit_odd: got bit_valid 1 expected no bit at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    chk("serial_odd", so1, e.b);
                    chk("frame_end_odd", fe1, e.last);
                    par1 = par1 ^ so1;
                    if (fe1) begin
                        chk("frame_xor_odd", par1, 1'b1);
                        par1 = 1'b0;
                    end
                end
            end else begin
                chk("frame_end_idle_odd", fe1, 1'b0);
            end
            pfe1 = fe1;
        end
    end

    task automatic push_frame(input logic [7:0] w, input logic even_par);
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{b: w[i], last: 1'b0});
            q1.push_back('{b: w[i], last: 1'b0});
        end
        q0.push_back('{b: even_par, last: 1'b1});
        q1.push_back('{b: ~even_par, last: 1'b1});
    endtask

    task automatic send(input logic [7:0] w, input logic even_par, input bit keep, output longint t);
        bit done;
        done = 0;
        t = 0;
        data_in = w;
        data_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (rdy0) begin
                push_frame(w, even_par);
                @(posedge clk);
                t = $time;
                #1;
                chk("first_bit_latency", bv0, 1'b1);
                if (!keep) data_valid = 1'b0;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            chk("accept_timeout", 1'b0, 1'b1);
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !bv0) done = 1;
        end
        if (!done) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        longint t1, t2;
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        longint t1, t2;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("idle_ready", rdy0, 1'b1);
            chk("idle_bit_valid", bv0, 1'b0);
            chk("idle_serial", so0, 1'b0);
            chk("idle_busy", busy0, 1'b0);
            @(posedge clk);
            #1;
        end

        // 0xA5 (4 ones, even parity 0) then idle with ready back
        send(8'hA5, 1'b0, 0, t1);
        wait_idle();
        chk("ready_after_frame", rdy0, 1'b1);
        chk("bit_valid_after_frame", bv0, 1'b0);

        // Parity sense: 0x07 (3 ones), 0x00
        send(8'h07, 1'b1, 0, t1);
        wait_idle();
        send(8'h00, 1'b0, 0, t1);
        wait_idle();

        // Held valid: 0x3C then 0xC3, both even parity 0
        send(8'h3C, 1'b0, 1, t1);
        send(8'hC3, 1'b0, 0, t2);
`ifdef PARGEN_BACK_TO_BACK_EN
        chk("frame_period", 32'((t2 - t1) / 10), 32'd9);
`else
        chk("frame_period", 32'((t2 - t1) / 10), 32'd10);
`endif
        wait_idle();

        // Reset during data bit 4 of 0xFF
        send(8'hFF, 1'b0, 0, t1);
        repeat (4) @(posedge clk);
        #2;
        chk("bit4_visible", bv0, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_serial", so0, 1'b0);
        chk("rst_bit_valid", bv0, 1'b0);
        chk("rst_frame_end", fe0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_frame_end_odd", fe1, 1'b0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'h01, 1'b1, 0, t1);
        wait_idle();

        // data_in churns while the frame is in flight; 0x5A has 4 ones
        send(8'h5A, 1'b0, 0, t1);
        for (int n = 0; n < 20 && busy0; n++) begin
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        wait_idle();

        chk("queue_even_drained", q0.size(), 0);
        chk("queue_odd_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
